// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, stall encoding, mem_op bit positions and the
//               EX->MEM bus layout for the MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 147;
  localparam int MEM_TO_WB_WD = 136;
  localparam int STALL_BUS_WD = 6;

  // Stall vector encoding and the bits this stage looks at
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam int   STALL_MEM_BIT = 3;
  localparam int   STALL_WB_BIT  = 4;

  // mem_op is one-hot
  localparam int OP_LB  = 4;
  localparam int OP_LBU = 3;
  localparam int OP_LH  = 2;
  localparam int OP_LHU = 1;
  localparam int OP_LW  = 0;

  // EX->MEM bus field offsets
  localparam int HILO_HI     = 146;
  localparam int HILO_LO     = 81;
  localparam int MEM_OP_HI   = 80;
  localparam int MEM_OP_LO   = 76;
  localparam int PC_HI       = 75;
  localparam int PC_LO       = 44;
  localparam int RAM_EN      = 43;
  localparam int RAM_WEN_HI  = 42;
  localparam int RAM_WEN_LO  = 39;
  localparam int SEL_RF_RES  = 38;
  localparam int RF_WE       = 37;
  localparam int RF_WADDR_HI = 36;
  localparam int RF_WADDR_LO = 32;
  localparam int RESULT_HI   = 31;
  localparam int RESULT_LO   = 0;

  // Packed view of the EX->MEM bus; field order matches the offsets above
  typedef struct packed {
    logic [65:0] hilo_bus;
    logic [4:0]  mem_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  function automatic logic is_load(input ex_to_mem_t e);
    return e.data_ram_en & (e.data_ram_wen == 4'b0000) & e.sel_rf_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational load-data formatter. Selects the byte / half /
//               word addressed by addr and sign- or zero-extends it.
//               Misaligned half/word accesses return zero.
// Ports       : word    in  32  raw memory word
//               addr    in  2   byte offset within the word
//               mem_op  in  5   one-hot {lb, lbu, lh, lhu, lw}
//               result  out 32  formatted load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [4:0]  mem_op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = '0;
    if (mem_op[OP_LB]) begin
      result = {{24{byte_sel[7]}}, byte_sel};
    end else if (mem_op[OP_LBU]) begin
      result = {24'b0, byte_sel};
    end else if (mem_op[OP_LH]) begin
      result = addr[0] ? 32'b0 : {{16{half_sel[15]}}, half_sel};
    end else if (mem_op[OP_LHU]) begin
      result = addr[0] ? 32'b0 : {16'b0, half_sel};
    end else if (mem_op[OP_LW]) begin
      result = (addr == 2'b00) ? word : 32'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage. Registers the EX->MEM bus, merges the
//               synchronous data-SRAM read data into the write-back value and
//               forwards the result to WB and ID. A one-entry hold register
//               keeps load data stable across MEM stalls.
// Ports       : clk              in  1    clock
//               rst              in  1    asynchronous active-high reset
//               flush            in  1    clear MEM pipeline register
//               stall            in  6    global stall vector (3=MEM, 4=WB)
//               ex_to_mem_bus    in  147  EX->MEM bus
//               data_sram_rdata  in  32   SRAM read data (load's 1st cycle)
//               mem_to_wb_bus    out 136  {hilo, pc, rf_we, rf_waddr, wdata}
//               mem_to_id_bus    out 38   {rf_we, rf_waddr, rf_wdata}
//               mem_to_id_hilo   out 66   hilo forwarding
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_BUS_WD-1:0] stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_bus,
  output logic [65:0]             mem_to_id_hilo
);

  ex_to_mem_t  r_q, r_d;
  logic        first_cyc_q, first_cyc_d;
  logic        hold_v_q, hold_v_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;

  logic        stall_mem;
  logic        stall_wb;
  logic        load;
  logic [31:0] load_word;
  logic [31:0] extracted;
  logic [31:0] rf_wdata;
  logic        unused_stall;

  assign stall_mem    = stall[STALL_MEM_BIT];
  assign stall_wb     = stall[STALL_WB_BIT];
  assign unused_stall = ^{stall[5], stall[2:0]};
  assign load         = is_load(r_q);

  always_comb begin
    r_d          = r_q;
    first_cyc_d  = 1'b0;
    hold_v_d     = hold_v_q;
    rdata_hold_d = rdata_hold_q;
    if (flush) begin
      r_d          = '0;
      hold_v_d     = 1'b0;
      rdata_hold_d = '0;
    end else if (stall_mem == STOP && stall_wb == NO_STOP) begin
      // MEM frozen but WB moving: hand WB a bubble
      r_d      = '0;
      hold_v_d = 1'b0;
    end else if (stall_mem == NO_STOP) begin
      r_d         = ex_to_mem_bus;
      first_cyc_d = 1'b1;
      hold_v_d    = 1'b0;
    end else if (load && first_cyc_q) begin
      // SRAM data is only valid now; keep it for the rest of the stall
      rdata_hold_d = data_sram_rdata;
      hold_v_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q          <= '0;
      first_cyc_q  <= 1'b0;
      hold_v_q     <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      r_q          <= r_d;
      first_cyc_q  <= first_cyc_d;
      hold_v_q     <= hold_v_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign load_word = first_cyc_q ? data_sram_rdata : rdata_hold_q;

  load_extract u_load_extract (
    .word   (load_word),
    .addr   (r_q.ex_result[1:0]),
    .mem_op (r_q.mem_op),
    .result (extracted)
  );

  assign rf_wdata       = load ? extracted : r_q.ex_result;
  assign mem_to_wb_bus  = {r_q.hilo_bus, r_q.pc, r_q.rf_we, r_q.rf_waddr, rf_wdata};
  assign mem_to_id_bus  = {r_q.rf_we, r_q.rf_waddr, rf_wdata};
  assign mem_to_id_hilo = r_q.hilo_bus;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage: registers the EX→MEM bus, merges synchronous data-SRAM read data into the write-back value, and forwards results to WB and ID. Loads issue their SRAM request in EX; read data arrives during the instruction's first MEM cycle. Load extraction (lb/lbu/lh/lhu/lw) uses the byte address. A one-entry read-data hold register keeps load results stable while MEM is stalled.

## Interface
- EX_TO_MEM_WD, 147, width of incoming bus.
- MEM_TO_WB_WD, 136, width of outgoing bus {hilo_bus[66], mem_pc[32], rf_we, rf_waddr[5], rf_wdata[32]}.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  clear MEM pipeline register.
- stall  in  StallBus  global stall vector; bit 3 = MEM, bit 4 = WB.
- ex_to_mem_bus  in  EX_TO_MEM_WD  fields: hilo_bus 146:81, mem_op 80:76, ex_pc 75:44, data_ram_en 43, data_ram_wen 42:39, sel_rf_res 38, rf_we 37, rf_waddr 36:32, ex_result 31:0.
- data_sram_rdata  in  32  SRAM read data, valid only in a load's first MEM cycle.
- mem_to_wb_bus  out  MEM_TO_WB_WD  result to WB.
- mem_to_id_bus  out  38  forwarding {rf_we, rf_waddr, rf_wdata}.
- mem_to_id_hilo  out  66  forwarding of hilo_bus.

## Operation
- Pipeline register `r`. Priority: rst (async) → 0; flush → 0; stall[3]=Stop & stall[4]=NoStop → 0 (bubble); stall[3]=NoStop → load ex_to_mem_bus; else hold.
- mem_op one-hot: [4] lb, [3] lbu, [2] lh, [1] lhu, [0] lw. Load = data_ram_en & data_ram_wen==0 & sel_rf_res.
- first_cyc flag: set to 1 whenever `r` loads a new (non-bubble) entry; cleared the next cycle; 0 on reset/flush/bubble.
- Hold register: on a load with first_cyc=1, capture data_sram_rdata into rdata_hold and set hold_v. hold_v clears when `r` loads a new entry or on flush/reset.
- Effective word: first_cyc ? data_sram_rdata : rdata_hold.
- Byte select by ex_result[1:0]: lb/lbu use byte n = bits 8n+7:8n; lh/lhu use half at [1]; lw whole word. Sign-extend lb/lh; zero-extend lbu/lhu.
- Misaligned lh/lhu (addr[0]=1) or lw (addr[1:0]≠0): rf_wdata = 0. rf_we passes through unchanged. No exception is raised.
- rf_wdata = load ? extracted : ex_result. hilo_bus and pc pass through unchanged.
- mem_to_id_bus mirrors the WB fields each cycle, including during a stall.

## Timing
- All outputs are combinational from `r`, first_cyc, the hold register and data_sram_rdata. There is no extra latency: an instruction's MEM result is visible in the cycle after EX.
- Reset: every output is 0. `r`, first_cyc, hold_v and rdata_hold are 0 immediately on rst assertion, independent of clk.
- While stalled, the output must be bit-identical in every stalled cycle, even if data_sram_rdata changes after the first cycle.
- flush has priority over stall. A flushed load never captures data.
- If rst is asserted mid-stall, the hold contents are discarded.

## Structure
- Shared package / defines.vh: EX_TO_MEM_WD, MEM_TO_WB_WD, StallBus, Stop/NoStop, the mem_op bit positions, and the bus field offsets.
- One sub-module: `load_extract` (combinational: word, addr[1:0], mem_op → 32-bit result). It is reused by any future cache-refill path.

## Test plan
- lw at addr 0x100, rdata=0x8899AABB, no stall → rf_wdata=0x8899AABB, rf_we=1 one cycle after EX.
- lb at addr 0x103 with rdata 0x80112233 → 0xFFFFFF80; lbu at the same address → 0x00000080; lh at 0x102 → 0xFFFF8011; lhu at 0x102 → 0x00008011.
- lw with rdata=0x12345678 in the first cycle, then MEM stalled 3 cycles while rdata changes to 0xDEADBEEF → rf_wdata stays 0x12345678 in all 4 cycles.
- stall[3]=Stop, stall[4]=NoStop for 1 cycle after an add (ex_result=5) → WB receives add once, then a bubble (rf_we=0, all zero).
- flush asserted the same cycle a load enters → next cycle mem_to_wb_bus=0 and hold_v=0.
- rst asserted asynchronously mid-cycle during a stalled load → outputs go to 0 before the next clk edge. After release, the first new lw produces correct data.
